// File: rtl/sram_bus_controller.sv
// SRAM bus controller: owns the external SRAM pins and time-multiplexes them
// between the 6502 bus port (sampled a fixed delay after phi_1 falls) and the
// VGA scan port. CPU requests take priority; VGA reads fill every idle slot.
//
// Completion handshake: cpuDone and vgaDataValid are single-cycle pulses with
// no back-pressure. The pulse is high in the cycle after the access's last
// edge, and cpuDataOut / vgaDataOut already hold the new value in that cycle.
// Those data outputs then stay unchanged until the next read on the same port.
module sram_bus_controller #(
  parameter int ACCESS_CYCLES = 2,
  parameter int SAMPLE_DELAY  = 4
) (
  input  logic        clkMem,
  input  logic        sysRstN,
  input  logic        phi_1,
  input  logic [15:0] cpuAddrBus,
  input  logic [7:0]  cpuDataIn,
  input  logic        cpuReN,
  input  logic        cpuWeN,
  output logic [7:0]  cpuDataOut,
  output logic        cpuDone,
  input  logic [15:0] vgaAddrBus,
  output logic [7:0]  vgaDataOut,
  output logic        vgaDataValid,
  output logic [15:0] memAddr,
  inout  wire  [7:0]  memData,
  output logic        memReN,
  output logic        memWeN,
  output logic [2:0]  dbgState
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] CPU_RD       = 3'd1;
  localparam logic [2:0] CPU_WR_SETUP = 3'd2;
  localparam logic [2:0] CPU_WR_PULSE = 3'd3;
  localparam logic [2:0] CPU_WR_HOLD  = 3'd4;
  localparam logic [2:0] VGA_RD       = 3'd5;

  localparam logic [2:0] ACC_LAST   = 3'(ACCESS_CYCLES - 1);
  localparam logic [3:0] DELAY_LOAD = 4'(SAMPLE_DELAY);

  logic        phiMeta;
  logic        phiSync;
  logic        phiSyncD;
  logic        phiFall;
  logic [3:0]  delayCnt;
  logic        sampleNow;

  logic        pendWr;
  logic        pendRd;
  logic [15:0] cpuAddrLat;
  logic [7:0]  cpuDataLat;

  logic [2:0]  state;
  logic [2:0]  accCnt;
  logic        lastAcc;
  logic        cpuComplete;
  logic [15:0] memAddrReg;
  logic [7:0]  wrData;
  logic        wrDrive;

  // Two-flop synchroniser for phi_1 plus a delayed copy for edge detection
  always_ff @(posedge clkMem) begin
    if (!sysRstN) begin
      phiMeta  <= 1'b0;
      phiSync  <= 1'b0;
      phiSyncD <= 1'b0;
    end else begin
      phiMeta  <= phi_1;
      phiSync  <= phiMeta;
      phiSyncD <= phiSync;
    end
  end

  assign phiFall   = phiSyncD & ~phiSync;
  assign sampleNow = (delayCnt == 4'd1);

  // Delay counter: reload on each phi_1 fall, count down, sample the CPU bus at 1
  always_ff @(posedge clkMem) begin
    if (!sysRstN) begin
      delayCnt <= 4'd0;
    end else if (phiFall) begin
      delayCnt <= DELAY_LOAD;
    end else if (delayCnt != 4'd0) begin
      delayCnt <= delayCnt - 4'd1;
    end
  end

  assign lastAcc     = (accCnt == ACC_LAST);
  assign cpuComplete = ((state == CPU_RD) && lastAcc) || (state == CPU_WR_HOLD);

  // Pending request register: a fresh sample overrides a same-edge completion clear
  always_ff @(posedge clkMem) begin
    if (!sysRstN) begin
      pendWr     <= 1'b0;
      pendRd     <= 1'b0;
      cpuAddrLat <= 16'h0000;
      cpuDataLat <= 8'h00;
    end else begin
      if (cpuComplete) begin
        pendWr <= 1'b0;
        pendRd <= 1'b0;
      end
      if (sampleNow) begin
        if (!cpuWeN) begin
          cpuAddrLat <= cpuAddrBus;
          cpuDataLat <= cpuDataIn;
          pendWr     <= 1'b1;
          pendRd     <= 1'b0;
        end else if (!cpuReN) begin
          cpuAddrLat <= cpuAddrBus;
          pendRd     <= 1'b1;
          pendWr     <= 1'b0;
        end
      end
    end
  end

  // Access sequencer: IDLE arbitrates for one turnaround cycle, accesses run to completion
  always_ff @(posedge clkMem) begin
    if (!sysRstN) begin
      state        <= IDLE;
      accCnt       <= 3'd0;
      memAddrReg   <= 16'h0000;
      wrData       <= 8'h00;
      cpuDataOut   <= 8'h00;
      vgaDataOut   <= 8'h00;
      cpuDone      <= 1'b0;
      vgaDataValid <= 1'b0;
    end else begin
      cpuDone      <= 1'b0;
      vgaDataValid <= 1'b0;
      case (state)
        IDLE: begin
          accCnt <= 3'd0;
          if (pendWr) begin
            memAddrReg <= cpuAddrLat;
            wrData     <= cpuDataLat;
            state      <= CPU_WR_SETUP;
          end else if (pendRd) begin
            memAddrReg <= cpuAddrLat;
            state      <= CPU_RD;
          end else begin
            memAddrReg <= vgaAddrBus;
            state      <= VGA_RD;
          end
        end
        CPU_RD: begin
          if (lastAcc) begin
            cpuDataOut <= memData;
            cpuDone    <= 1'b1;
            state      <= IDLE;
          end else begin
            accCnt <= accCnt + 3'd1;
          end
        end
        VGA_RD: begin
          if (lastAcc) begin
            vgaDataOut   <= memData;
            vgaDataValid <= 1'b1;
            state        <= IDLE;
          end else begin
            accCnt <= accCnt + 3'd1;
          end
        end
        CPU_WR_SETUP: begin
          accCnt <= 3'd0;
          state  <= CPU_WR_PULSE;
        end
        CPU_WR_PULSE: begin
          if (lastAcc) begin
            state <= CPU_WR_HOLD;
          end else begin
            accCnt <= accCnt + 3'd1;
          end
        end
        CPU_WR_HOLD: begin
          cpuDone <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode straight from the state register, so they can never overlap
  assign memReN  = !((state == CPU_RD) || (state == VGA_RD));
  assign memWeN  = (state != CPU_WR_PULSE);
  assign wrDrive = (state == CPU_WR_SETUP) || (state == CPU_WR_PULSE) ||
                   (state == CPU_WR_HOLD);
  assign memData  = wrDrive ? wrData : 8'hzz;
  assign memAddr  = memAddrReg;
  assign dbgState = state;

endmodule

// File: tb/tb_sram_bus_controller.sv
// Bench for sram_bus_controller: SRAM device model on the pins, table of CPU
// transactions with hand-computed results, plus VGA streaming, arbitration
// alignment and mid-write reset sequences.
module tb_sram_bus_controller;

  localparam int ACCESS_CYCLES = 2;
  localparam int SAMPLE_DELAY  = 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_RD   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_VGA_RD   = 3'd5;

  logic        clkMem;
  logic        sysRstN;
  logic        phi_1;
  logic [15:0] cpuAddrBus;
  logic [7:0]  cpuDataIn;
  logic        cpuReN;
  logic        cpuWeN;
  logic [7:0]  cpuDataOut;
  logic        cpuDone;
  logic [15:0] vgaAddrBus;
  logic [7:0]  vgaDataOut;
  logic        vgaDataValid;
  logic [15:0] memAddr;
  wire  [7:0]  memData;
  logic        memReN;
  logic        memWeN;
  logic [2:0]  dbgState;

  int errors = 0;
  int checks = 0;

  sram_bus_controller #(
    .ACCESS_CYCLES(ACCESS_CYCLES),
    .SAMPLE_DELAY (SAMPLE_DELAY)
  ) dut (
    .clkMem      (clkMem),
    .sysRstN     (sysRstN),
    .phi_1       (phi_1),
    .cpuAddrBus  (cpuAddrBus),
    .cpuDataIn   (cpuDataIn),
    .cpuReN      (cpuReN),
    .cpuWeN      (cpuWeN),
    .cpuDataOut  (cpuDataOut),
    .cpuDone     (cpuDone),
    .vgaAddrBus  (vgaAddrBus),
    .vgaDataOut  (vgaDataOut),
    .vgaDataValid(vgaDataValid),
    .memAddr     (memAddr),
    .memData     (memData),
    .memReN      (memReN),
    .memWeN      (memWeN),
    .dbgState    (dbgState)
  );

  // ---------------- clock ----------------
  initial begin
    clkMem = 1'b0;
    forever #5 clkMem = ~clkMem;
  end

  // ---------------- SRAM device model ----------------
  // Power-up contents are patt(addr); the array stores the XOR delta so it
  // starts as all zero.
  function automatic logic [7:0] patt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0] sramDelta [0:65535] = '{default: 8'h00};

  always @(posedge clkMem) begin
    if (!memWeN) sramDelta[memAddr] <= memData ^ patt(memAddr);
  end

  assign memData = (!memReN) ? (sramDelta[memAddr] ^ patt(memAddr)) : 8'hzz;

  // A released bus reads as FF
  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (memData[i]);
  end

  // ---------------- global monitors ----------------
  int bothLow  = 0;
  int cpuStray = 0;
  int vgaStray = 0;
  logic [7:0] prevCpuOut = 8'h00;
  logic [7:0] prevVgaOut = 8'h00;

  always @(negedge clkMem) begin
    if (sysRstN) begin
      if (!memReN && !memWeN) bothLow <= bothLow + 1;
      if (cpuDataOut != prevCpuOut && !cpuDone) cpuStray <= cpuStray + 1;
      if (vgaDataOut != prevVgaOut && !vgaDataValid) vgaStray <= vgaStray + 1;
    end
    prevCpuOut <= cpuDataOut;
    prevVgaOut <= vgaDataOut;
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkLe(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endtask

  // ---------------- CPU transaction driver ----------------
  typedef struct {
    logic        weN;
    logic        reN;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        expWr;
    logic        expRd;
    logic        expDone;
    logic [7:0]  expCpuOut;
  } cpuVec_t;

  int       doneCnt, wrCyc, wrBad, weLow, rdLow, doneAt;
  logic     turnOk;
  logic [7:0] vgaAtTurn;

  task automatic runCpu(input cpuVec_t v);
    logic       firstRd;
    logic [2:0] prevSt;
    logic       prevVal;
    logic [7:0] prevVga;
    doneCnt = 0; wrCyc = 0; wrBad = 0; weLow = 0; rdLow = 0; doneAt = 0;
    turnOk = 1'b0; vgaAtTurn = 8'h00;
    firstRd = 1'b0; prevSt = dbgState; prevVal = vgaDataValid; prevVga = vgaDataOut;
    cpuWeN = v.weN; cpuReN = v.reN; cpuAddrBus = v.addr; cpuDataIn = v.data;
    phi_1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clkMem);
      if (cpuDone) doneCnt++;
      if (dbgState == S_WR_SETUP || dbgState == S_WR_PULSE || dbgState == S_WR_HOLD) begin
        wrCyc++;
        if (memAddr != v.addr || memData != v.data) wrBad++;
      end
      if (!memWeN) weLow++;
      if (dbgState == S_CPU_RD && !memReN && memAddr == v.addr) rdLow++;
      if (dbgState == S_CPU_RD && !firstRd) begin
        firstRd   = 1'b1;
        turnOk    = (prevSt == S_IDLE) && prevVal;
        vgaAtTurn = prevVga;
      end
      prevSt = dbgState; prevVal = vgaDataValid; prevVga = vgaDataOut;
      if (cpuDone && doneAt == 0) doneAt = c;
      if (doneAt != 0 && c >= doneAt + 4) break;
    end
    phi_1 = 1'b1; cpuWeN = 1'b1; cpuReN = 1'b1;
    repeat (3) @(negedge clkMem);
  endtask

  task automatic checkVec(input string tag, input cpuVec_t v);
    check({tag, " done"}, doneCnt, {31'd0, v.expDone});
    check({tag, " cpuDataOut"}, cpuDataOut, v.expCpuOut);
    if (v.expWr) begin
      check({tag, " wrCycles"}, wrCyc, ACCESS_CYCLES + 2);
      check({tag, " weLow"}, weLow, ACCESS_CYCLES);
      check({tag, " wrStable"}, wrBad, 0);
    end else begin
      check({tag, " noWrite"}, weLow, 0);
    end
    if (v.expRd) check({tag, " rdLow"}, rdLow, ACCESS_CYCLES);
    else         check({tag, " noCpuRd"}, rdLow, 0);
  endtask

  // ---------------- test sequence ----------------
  cpuVec_t vecs [6];
  cpuVec_t alignVec;
  cpuVec_t rstVec;

  initial begin
    // weN reN addr data expWr expRd expDone expCpuOut
    vecs[0] = '{1'b0, 1'b1, 16'h0400, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h00}; // write A5
    vecs[1] = '{1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5}; // read back
    vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b1, 1'b1, 8'h7C}; // power-up data
    vecs[3] = '{1'b0, 1'b0, 16'h0500, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h7C}; // both low: write
    vecs[4] = '{1'b1, 1'b1, 16'h0600, 8'h99, 1'b0, 1'b0, 1'b0, 8'h7C}; // no request
    vecs[5] = '{1'b1, 1'b0, 16'h0500, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C}; // read 0500
    alignVec = '{1'b1, 1'b0, 16'h0400, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5};
    rstVec   = '{1'b0, 1'b1, 16'h0700, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h00};

    sysRstN = 1'b0; phi_1 = 1'b1;
    cpuAddrBus = 16'h0000; cpuDataIn = 8'h00; cpuReN = 1'b1; cpuWeN = 1'b1;
    vgaAddrBus = 16'h2000;

    // Reset state
    repeat (3) @(negedge clkMem);
    check("rst memReN", memReN, 1'b1);
    check("rst memWeN", memWeN, 1'b1);
    check("rst memAddr", memAddr, 16'h0000);
    check("rst memData", memData, 8'hFF);
    check("rst cpuDataOut", cpuDataOut, 8'h00);
    check("rst vgaDataOut", vgaDataOut, 8'h00);
    check("rst cpuDone", cpuDone, 1'b0);
    check("rst vgaDataValid", vgaDataValid, 1'b0);
    check("rst state", dbgState, S_IDLE);
    sysRstN = 1'b1;

    // VGA streaming with no CPU traffic
    begin
      int gap;
      int vgaWe;
      logic [15:0] curAddr;
      vgaWe = 0;
      gap = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clkMem);
        if (vgaDataValid) break;
      end
      check("vga first valid", vgaDataValid, 1'b1);
      curAddr = 16'h2000;
      vgaAddrBus = curAddr;
      for (int i = 0; i < 6; i++) begin
        gap = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clkMem);
          gap++;
          if (!memWeN) vgaWe++;
          if (vgaDataValid) break;
        end
        check($sformatf("vga period %0d", i), gap, 3);
        check($sformatf("vga data %0h", curAddr), vgaDataOut, patt(curAddr));
        curAddr = curAddr + 16'd1;
        vgaAddrBus = curAddr;
      end
      check("vga no write", vgaWe, 0);
    end

    // Table of CPU transactions
    for (int i = 0; i < 6; i++) begin
      runCpu(vecs[i]);
      checkVec($sformatf("vec%0d", i), vecs[i]);
    end

    // CPU sample landing on the edge where IDLE picks VGA: VGA finishes first
    for (int k = 0; k < 20; k++) begin
      @(negedge clkMem);
      if (dbgState == S_IDLE) break;
    end
    check("align idle", dbgState, S_IDLE);
    runCpu(alignVec);
    checkVec("align", alignVec);
    check("align vga then idle", turnOk, 1'b1);
    check("align vga data", vgaAtTurn, patt(16'h2006));
    checkLe("align latency", doneAt, 3 + SAMPLE_DELAY + 9);
    check("align done seen", doneAt != 0, 1'b1);

    // Reset during the write pulse aborts the access
    begin
      int spurious;
      cpuWeN = rstVec.weN; cpuReN = rstVec.reN;
      cpuAddrBus = rstVec.addr; cpuDataIn = rstVec.data;
      phi_1 = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clkMem);
        if (dbgState == S_WR_PULSE) break;
      end
      check("pre-rst pulse", memWeN, 1'b0);
      sysRstN = 1'b0;
      @(negedge clkMem);
      check("mid-rst memWeN", memWeN, 1'b1);
      check("mid-rst memReN", memReN, 1'b1);
      check("mid-rst memData", memData, 8'hFF);
      check("mid-rst memAddr", memAddr, 16'h0000);
      check("mid-rst cpuDataOut", cpuDataOut, 8'h00);
      check("mid-rst vgaDataOut", vgaDataOut, 8'h00);
      check("mid-rst state", dbgState, S_IDLE);
      phi_1 = 1'b1; cpuWeN = 1'b1; cpuReN = 1'b1;
      @(negedge clkMem);
      sysRstN = 1'b1;
      spurious = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clkMem);
        if (cpuDone) spurious++;
      end
      check("post-rst no cpuDone", spurious, 0);
    end

    check("strobes never both low", bothLow, 0);
    check("cpuDataOut only moves on cpuDone", cpuStray, 0);
    check("vgaDataOut only moves on valid", vgaStray, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
